// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bist_drv2_pkg.sv
// Shared definitions for the 2-input cell BIST driver family.
package gf180mcu_fd_sc_mcu9t5v0__bist_drv2_pkg;

    // Run sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } bist_state_e;

    // Expected ZN indexed by {A2,A1}
    localparam logic [3:0] TRUTH_NOR2 = 4'b0001;
    localparam logic [3:0] TRUTH_AND2 = 4'b1000;
    localparam logic [3:0] TRUTH_OR2  = 4'b1110;
    localparam logic [3:0] TRUTH_NAND2 = 4'b0111;
    localparam logic [3:0] TRUTH_XOR2 = 4'b0110;

    // Default MISR feedback polynomial (CCITT); lower SIG_W bits are used
    localparam logic [31:0] POLY_DEFAULT = 32'h0000_1021;

    localparam int unsigned VEC_W    = 2;
    localparam int unsigned ERR_W    = 8;
    localparam int unsigned PASS_W   = 8;
    localparam int unsigned SETTLE_W = 4;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bist_misr.sv
// Serial-input MISR response compactor; din enters at bit 0.
module gf180mcu_fd_sc_mcu9t5v0__bist_misr #(
    parameter int unsigned SIG_W = 16,
    parameter logic [31:0] POLY  = 32'h0000_1021
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    localparam logic [SIG_W-1:0] POLY_W = POLY[SIG_W-1:0];

    // Signature register: clear has priority over a shift
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[SIG_W-2:0], 1'b0}
                 ^ (sig[SIG_W-1] ? POLY_W : '0)
                 ^ SIG_W'(din);
        end
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bist_drv2.sv
// Exhaustive BIST driver for a 2-input cell: stimulus, compare, compaction.
module gf180mcu_fd_sc_mcu9t5v0__bist_drv2
    import gf180mcu_fd_sc_mcu9t5v0__bist_drv2_pkg::*;
#(
    parameter logic [3:0]  TRUTH  = TRUTH_NOR2,
    parameter int unsigned REPEAT = 4,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned SIG_W  = 16,
    parameter logic [31:0] POLY   = POLY_DEFAULT
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    input  logic             ZN_IN,
    output logic             A1,
    output logic             A2,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [SIG_W-1:0] SIG
);

    // With no settle time each vector is driven and sampled in a single cycle
    localparam bist_state_e            FIRST_ST    = (SETTLE == 0) ? ST_SAMPLE : ST_DRIVE;
    localparam logic [SETTLE_W-1:0]    SETTLE_LAST = SETTLE_W'((SETTLE == 0) ? 0 : SETTLE - 1);
    localparam logic [PASS_W-1:0]      LAST_PASS   = PASS_W'(REPEAT - 1);
    localparam logic [VEC_W-1:0]       LAST_VEC    = VEC_W'(3);
    localparam logic [ERR_W-1:0]       ERR_MAX     = '1;

    bist_state_e         state, state_d;
    logic [VEC_W-1:0]    vec, vec_d;
    logic [PASS_W-1:0]   pass_cnt, pass_d;
    logic [SETTLE_W-1:0] settle, settle_d;
    logic [VEC_W-1:0]    a_d;
    logic                busy_d, done_d, pass_ok_d;
    logic [ERR_W-1:0]    err_d;
    logic                misr_clr, misr_en;
    logic                mismatch;

    // Next-state and next-output logic
    always_comb begin
        state_d   = state;
        vec_d     = vec;
        pass_d    = pass_cnt;
        settle_d  = settle;
        a_d       = {A2, A1};
        busy_d    = BUSY;
        done_d    = DONE;
        pass_ok_d = PASS;
        err_d     = ERR_CNT;
        misr_clr  = 1'b0;
        misr_en   = 1'b0;
        mismatch  = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_d   = FIRST_ST;
                    vec_d     = '0;
                    pass_d    = '0;
                    settle_d  = '0;
                    a_d       = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_ok_d = 1'b0;
                    err_d     = '0;
                    misr_clr  = 1'b1;
                end
            end

            ST_DRIVE: begin
                settle_d = settle + SETTLE_W'(1);
                if (settle == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                misr_en  = 1'b1;
                mismatch = (ZN_IN != TRUTH[vec]);
                if (mismatch && (ERR_CNT != ERR_MAX)) begin
                    err_d = ERR_CNT + ERR_W'(1);
                end
                settle_d = '0;
                vec_d    = vec + VEC_W'(1);
                if (vec == LAST_VEC) begin
                    pass_d = pass_cnt + PASS_W'(1);
                end
                if ((vec == LAST_VEC) && (pass_cnt == LAST_PASS)) begin
                    state_d   = ST_DONE;
                    vec_d     = '0;
                    pass_d    = '0;
                    a_d       = '0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    pass_ok_d = (err_d == '0);
                end else begin
                    state_d = FIRST_ST;
                    a_d     = vec_d;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state    <= ST_IDLE;
            vec      <= '0;
            pass_cnt <= '0;
            settle   <= '0;
            A1       <= 1'b0;
            A2       <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            PASS     <= 1'b0;
            ERR_CNT  <= '0;
        end else begin
            state    <= state_d;
            vec      <= vec_d;
            pass_cnt <= pass_d;
            settle   <= settle_d;
            A1       <= a_d[0];
            A2       <= a_d[1];
            BUSY     <= busy_d;
            DONE     <= done_d;
            PASS     <= pass_ok_d;
            ERR_CNT  <= err_d;
        end
    end

    // Response compactor
    gf180mcu_fd_sc_mcu9t5v0__bist_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_misr (
        .CLK (CLK),
        .RN  (RN),
        .clr (misr_clr),
        .en  (misr_en),
        .din (ZN_IN),
        .sig (SIG)
    );

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__bist_drv2.sv
// Directed bench for the 2-input cell BIST driver.
module tb_gf180mcu_fd_sc_mcu9t5v0__bist_drv2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Four instances: default, REPEAT=100, SETTLE=0, SETTLE=3
    logic        start [4];
    logic        zn    [4];
    logic        a1    [4];
    logic        a2    [4];
    logic        busy  [4];
    logic        done  [4];
    logic        pass  [4];
    logic [7:0]  err   [4];
    logic [15:0] sig   [4];
    int          mode  [4];

    // Cell model: 0 good NOR2, 1 stuck-0, 2 stuck-1, 3 OR2-like (inverted)
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            case (mode[i])
                0:       zn[i] = ~(a1[i] | a2[i]);
                1:       zn[i] = 1'b0;
                2:       zn[i] = 1'b1;
                default: zn[i] = a1[i] | a2[i];
            endcase
        end
    end

    gf180mcu_fd_sc_mcu9t5v0__bist_drv2 u0 (
        .CLK(clk), .RN(rst_n), .START(start[0]), .ZN_IN(zn[0]), .A1(a1[0]), .A2(a2[0]),
        .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]), .ERR_CNT(err[0]), .SIG(sig[0]));
    gf180mcu_fd_sc_mcu9t5v0__bist_drv2 #(.REPEAT(100)) u1 (
        .CLK(clk), .RN(rst_n), .START(start[1]), .ZN_IN(zn[1]), .A1(a1[1]), .A2(a2[1]),
        .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]), .ERR_CNT(err[1]), .SIG(sig[1]));
    gf180mcu_fd_sc_mcu9t5v0__bist_drv2 #(.SETTLE(0)) u2 (
        .CLK(clk), .RN(rst_n), .START(start[2]), .ZN_IN(zn[2]), .A1(a1[2]), .A2(a2[2]),
        .BUSY(busy[2]), .DONE(done[2]), .PASS(pass[2]), .ERR_CNT(err[2]), .SIG(sig[2]));
    gf180mcu_fd_sc_mcu9t5v0__bist_drv2 #(.SETTLE(3)) u3 (
        .CLK(clk), .RN(rst_n), .START(start[3]), .ZN_IN(zn[3]), .A1(a1[3]), .A2(a2[3]),
        .BUSY(busy[3]), .DONE(done[3]), .PASS(pass[3]), .ERR_CNT(err[3]), .SIG(sig[3]));

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Reference MISR: nib[v] is the ZN value seen for vector v, vectors 0..3 per pass
    function automatic logic [15:0] misr_ref(input logic [3:0] nib, input int reps);
        logic [15:0] s;
        logic        fb;
        s = '0;
        for (int r = 0; r < reps; r++) begin
            for (int v = 0; v < 4; v++) begin
                fb = s[15];
                s  = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000) ^ {15'b0, nib[v]};
            end
        end
        return s;
    endfunction

    // Pulse START, then watch one run; ra/rb are cycles at which START is re-pulsed
    task automatic run(input int k, input int s, input int budget, input int ra, input int rb,
                       output int nbusy, output int nstim_bad, output bit done_ok);
        @(negedge clk) start[k] = 1'b1;
        @(negedge clk) start[k] = 1'b0;
        nbusy = 0;
        nstim_bad = 0;
        done_ok = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            start[k] = (c == ra) || (c == rb);
            if (done[k]) begin
                done_ok = 1'b1;
                break;
            end
            if (busy[k]) begin
                if ({a2[k], a1[k]} != 2'((nbusy / (s + 1)) % 4)) nstim_bad++;
                nbusy++;
            end
            @(negedge clk);
        end
        start[k] = 1'b0;
    endtask

    typedef struct {
        string      name;
        int         mode;
        logic [3:0] nib;
        logic [7:0] exp_err;
        logic       exp_pass;
    } vec_t;

    vec_t tbl [4];
    int   nb, nsb, n;
    bit   dok;

    initial begin
        tbl[0] = '{"good",   0, 4'b0001, 8'd0,  1'b1};
        tbl[1] = '{"stuck0", 1, 4'b0000, 8'd4,  1'b0};
        tbl[2] = '{"stuck1", 2, 4'b1111, 8'd12, 1'b0};
        tbl[3] = '{"or2",    3, 4'b1110, 8'd16, 1'b0};

        for (int i = 0; i < 4; i++) begin
            start[i] = 1'b0;
            mode[i]  = 0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ctl", {27'b0, a1[0], a2[0], busy[0], done[0], pass[0]}, 32'd0);
        check("rst_err", 32'(err[0]), 32'd0);
        check("rst_sig", 32'(sig[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven runs on the default instance
        for (int i = 0; i < 4; i++) begin
            mode[0] = tbl[i].mode;
            run(0, 1, 200, -1, -1, nb, nsb, dok);
            check({tbl[i].name, "_done"}, 32'(dok), 32'd1);
            check({tbl[i].name, "_busy"}, 32'(nb), 32'd32);
            check({tbl[i].name, "_stim"}, 32'(nsb), 32'd0);
            check({tbl[i].name, "_err"}, 32'(err[0]), 32'(tbl[i].exp_err));
            check({tbl[i].name, "_pass"}, 32'(pass[0]), 32'(tbl[i].exp_pass));
            check({tbl[i].name, "_sig"}, 32'(sig[0]), 32'(misr_ref(tbl[i].nib, 4)));
            check({tbl[i].name, "_a"}, {30'b0, a2[0], a1[0]}, 32'd0);
            @(negedge clk);
            check({tbl[i].name, "_done_lvl"}, {30'b0, done[0], busy[0]}, 32'd2);
        end

        // START re-pulsed mid-run is ignored
        mode[0] = 0;
        run(0, 1, 200, 5, 20, nb, nsb, dok);
        check("repulse_done", 32'(dok), 32'd1);
        check("repulse_busy", 32'(nb), 32'd32);
        check("repulse_pass", 32'(pass[0]), 32'd1);

        // START held high: exactly one DONE cycle between runs
        @(negedge clk) start[0] = 1'b1;
        @(negedge clk);
        n = 0;
        while (!done[0] && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("hold_first_len", 32'(n), 32'd32);
        n = 0;
        while (done[0] && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("hold_done_cycles", 32'(n), 32'd1);
        check("hold_rerun_busy", 32'(busy[0]), 32'd1);
        start[0] = 1'b0;
        n = 0;
        while (!done[0] && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("hold_second_done", 32'(done[0]), 32'd1);

        // Asynchronous reset mid-run, then a fresh run
        mode[0] = 2;
        @(negedge clk) start[0] = 1'b1;
        @(negedge clk) start[0] = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_err", 32'(err[0]), 32'd3);
        rst_n = 1'b0;
        #1;
        check("async_rst_ctl", {27'b0, a1[0], a2[0], busy[0], done[0], pass[0]}, 32'd0);
        check("async_rst_err", 32'(err[0]), 32'd0);
        check("async_rst_sig", 32'(sig[0]), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        mode[0] = 0;
        run(0, 1, 200, -1, -1, nb, nsb, dok);
        check("post_rst_done", 32'(dok), 32'd1);
        check("post_rst_busy", 32'(nb), 32'd32);
        check("post_rst_err", 32'(err[0]), 32'd0);
        check("post_rst_sig", 32'(sig[0]), 32'(misr_ref(4'b0001, 4)));

        // Saturation: 300 mismatches clamp at 255
        mode[1] = 2;
        run(1, 1, 1000, -1, -1, nb, nsb, dok);
        check("sat_done", 32'(dok), 32'd1);
        check("sat_busy", 32'(nb), 32'd800);
        check("sat_err", 32'(err[1]), 32'd255);
        check("sat_pass", 32'(pass[1]), 32'd0);
        check("sat_sig", 32'(sig[1]), 32'(misr_ref(4'b1111, 100)));

        // SETTLE=0: one cycle per vector
        run(2, 0, 100, -1, -1, nb, nsb, dok);
        check("s0_done", 32'(dok), 32'd1);
        check("s0_busy", 32'(nb), 32'd16);
        check("s0_stim", 32'(nsb), 32'd0);
        check("s0_pass", 32'(pass[2]), 32'd1);
        check("s0_sig", 32'(sig[2]), 32'(misr_ref(4'b0001, 4)));

        // SETTLE=3: four cycles per vector
        run(3, 3, 200, -1, -1, nb, nsb, dok);
        check("s3_done", 32'(dok), 32'd1);
        check("s3_busy", 32'(nb), 32'd64);
        check("s3_stim", 32'(nsb), 32'd0);
        check("s3_pass", 32'(pass[3]), 32'd1);
        check("s3_sig", 32'(sig[3]), 32'(misr_ref(4'b0001, 4)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
